// File: rtl/chip_top.sv
// Board self-test: UART banner, SPI loopback test with P/F verdict, then UART echo.
// A free-running VGA timing generator draws a coordinate-derived test pattern.
module chip_top #(
    parameter int BAUD_DIV = 16,
    parameter int SPI_DIV  = 4,
    parameter int PIX_DIV  = 8,
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk_p,
    input  logic       clk_n,
    input  logic       rst_top,
    input  logic       rxd,
    output logic       txd,
    output logic       spi_cs,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       sd_reset,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue,
    output logic       vga_hsync,
    output logic       vga_vsync
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_MID  = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] SPI_LAST  = 16'(SPI_DIV - 1);
    localparam logic [15:0] PIX_LAST  = 16'(PIX_DIV - 1);
    localparam logic [11:0] H_ACT_L   = 12'(H_ACT);
    localparam logic [11:0] HS_START  = 12'(H_ACT + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACT + H_FP + H_SYNC - 1);
    localparam logic [11:0] H_LAST    = 12'(H_ACT + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT_L   = 12'(V_ACT);
    localparam logic [11:0] VS_START  = 12'(V_ACT + V_FP);
    localparam logic [11:0] VS_END    = 12'(V_ACT + V_FP + V_SYNC - 1);
    localparam logic [11:0] V_LAST    = 12'(V_ACT + V_FP + V_SYNC + V_BP - 1);
    localparam logic [7:0]  SPI_PATTERN = 8'hA5;

    typedef enum logic [1:0] {
        ST_BANNER = 2'd0,
        ST_SPI    = 2'd1,
        ST_RESULT = 2'd2,
        ST_ECHO   = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    seq_state_t state_r;
    rx_state_t  rx_state_r;

    logic [2:0]  ban_idx_r;
    logic        tx_busy_r;
    logic [8:0]  tx_data_r;
    logic [3:0]  tx_bit_r;
    logic [15:0] tx_baud_r;
    logic [15:0] spi_half_r;
    logic [4:0]  spi_phase_r;
    logic [7:0]  spi_tx_r;
    logic [7:0]  spi_rx_r;
    logic        hold_full_r;
    logic [7:0]  hold_data_r;
    logic        rx_sync1_r;
    logic        rx_sync2_r;
    logic        rx_prev_r;
    logic [15:0] rx_baud_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_valid_r;
    logic [15:0] pix_r;
    logic [11:0] h_r;
    logic [11:0] v_r;

    logic        tx_done_s;
    logic        tx_free_s;
    logic        tx_load_s;
    logic [7:0]  tx_byte_s;
    logic        unused_clk_n_s;

    assign unused_clk_n_s = clk_n;

    function automatic logic [7:0] banner_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    banner_byte = 8'h4F;
            2'd1:    banner_byte = 8'h4B;
            2'd2:    banner_byte = 8'h0D;
            2'd3:    banner_byte = 8'h0A;
            default: banner_byte = 8'h0A;
        endcase
    endfunction

    assign tx_done_s = tx_busy_r && (tx_baud_r == BAUD_LAST) && (tx_bit_r == 4'd9);
    assign tx_free_s = !tx_busy_r || tx_done_s;

    // Choose the next byte for the transmitter; a load on the last stop cycle keeps bytes gap-free.
    always_comb begin
        tx_load_s = 1'b0;
        tx_byte_s = 8'h00;
        case (state_r)
            ST_BANNER: begin
                if (tx_free_s && (ban_idx_r < 3'd4)) begin
                    tx_load_s = 1'b1;
                    tx_byte_s = banner_byte(ban_idx_r[1:0]);
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            ST_RESULT: begin
                if (tx_free_s) begin
                    tx_load_s = 1'b1;
                    tx_byte_s = (spi_rx_r == SPI_PATTERN) ? 8'h50 : 8'h46;
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            ST_ECHO: begin
                if (tx_free_s && hold_full_r) begin
                    tx_load_s = 1'b1;
                    tx_byte_s = hold_data_r;
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            default: begin
                tx_load_s = 1'b0;
            end
        endcase
    end

    // Sequencer, UART transmitter, SPI master and echo holding register.
    always_ff @(posedge clk_p) begin
        if (rst_top) begin
            state_r     <= ST_BANNER;
            ban_idx_r   <= 3'd0;
            txd         <= 1'b1;
            tx_busy_r   <= 1'b0;
            tx_data_r   <= 9'h1FF;
            tx_bit_r    <= 4'd0;
            tx_baud_r   <= 16'd0;
            spi_cs      <= 1'b1;
            spi_sclk    <= 1'b0;
            spi_mosi    <= 1'b0;
            spi_half_r  <= 16'd0;
            spi_phase_r <= 5'd0;
            spi_tx_r    <= 8'h00;
            spi_rx_r    <= 8'h00;
            sd_reset    <= 1'b1;
            hold_full_r <= 1'b0;
            hold_data_r <= 8'h00;
        end else begin
            if (tx_busy_r) begin
                if (tx_baud_r == BAUD_LAST) begin
                    tx_baud_r <= 16'd0;
                    if (tx_bit_r == 4'd9) begin
                        tx_busy_r <= 1'b0;
                    end else begin
                        txd       <= tx_data_r[0];
                        tx_data_r <= {1'b1, tx_data_r[8:1]};
                        tx_bit_r  <= tx_bit_r + 4'd1;
                    end
                end else begin
                    tx_baud_r <= tx_baud_r + 16'd1;
                end
            end

            if (tx_load_s) begin
                txd       <= 1'b0;
                tx_data_r <= {1'b1, tx_byte_s};
                tx_bit_r  <= 4'd0;
                tx_baud_r <= 16'd0;
                tx_busy_r <= 1'b1;
            end

            case (state_r)
                ST_BANNER: begin
                    if (tx_load_s) begin
                        ban_idx_r <= ban_idx_r + 3'd1;
                    end else if ((ban_idx_r == 3'd4) && tx_free_s) begin
                        state_r     <= ST_SPI;
                        sd_reset    <= 1'b0;
                        spi_cs      <= 1'b0;
                        spi_tx_r    <= SPI_PATTERN;
                        spi_mosi    <= SPI_PATTERN[7];
                        spi_half_r  <= 16'd0;
                        spi_phase_r <= 5'd0;
                    end
                end
                ST_SPI: begin
                    // Even half-period ends raise SCLK and sample; odd ones lower it and shift.
                    if (spi_half_r == SPI_LAST) begin
                        spi_half_r  <= 16'd0;
                        spi_phase_r <= spi_phase_r + 5'd1;
                        if (spi_phase_r == 5'd16) begin
                            spi_cs   <= 1'b1;
                            spi_mosi <= 1'b0;
                            state_r  <= ST_RESULT;
                        end else if (!spi_phase_r[0]) begin
                            spi_sclk <= 1'b1;
                            spi_rx_r <= {spi_rx_r[6:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            spi_mosi <= spi_tx_r[6];
                            spi_tx_r <= {spi_tx_r[6:0], 1'b0};
                        end
                    end else begin
                        spi_half_r <= spi_half_r + 16'd1;
                    end
                end
                ST_RESULT: begin
                    if (tx_load_s) begin
                        state_r <= ST_ECHO;
                    end
                end
                ST_ECHO: begin
                    if (tx_load_s) begin
                        hold_full_r <= 1'b0;
                    end
                    if (rx_valid_r && !hold_full_r) begin
                        hold_full_r <= 1'b1;
                        hold_data_r <= rx_shift_r;
                    end
                end
                default: begin
                    state_r <= ST_BANNER;
                end
            endcase
        end
    end

    // UART receiver: synchroniser, start-bit qualification and mid-bit sampling; armed only in ECHO.
    always_ff @(posedge clk_p) begin
        if (rst_top) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_baud_r  <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            rx_sync1_r <= rxd;
            rx_sync2_r <= rx_sync1_r;
            rx_prev_r  <= rx_sync2_r;
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if ((state_r == ST_ECHO) && rx_prev_r && !rx_sync2_r) begin
                        rx_state_r <= RX_START;
                        rx_baud_r  <= 16'd0;
                    end
                end
                RX_START: begin
                    if (rx_baud_r == BAUD_MID) begin
                        rx_baud_r  <= 16'd0;
                        rx_bit_r   <= 3'd0;
                        rx_state_r <= rx_sync2_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud_r <= rx_baud_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud_r == BAUD_LAST) begin
                        rx_baud_r  <= 16'd0;
                        rx_shift_r <= {rx_sync2_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_baud_r <= rx_baud_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_baud_r == BAUD_LAST) begin
                        rx_baud_r  <= 16'd0;
                        rx_state_r <= RX_IDLE;
                        rx_valid_r <= rx_sync2_r;
                    end else begin
                        rx_baud_r <= rx_baud_r + 16'd1;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // VGA pixel/line counters and registered sync and colour outputs.
    always_ff @(posedge clk_p) begin
        if (rst_top) begin
            pix_r     <= 16'd0;
            h_r       <= 12'd0;
            v_r       <= 12'd0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_red   <= 4'd0;
            vga_green <= 4'd0;
            vga_blue  <= 4'd0;
        end else begin
            if (pix_r == PIX_LAST) begin
                pix_r <= 16'd0;
                if (h_r == H_LAST) begin
                    h_r <= 12'd0;
                    v_r <= (v_r == V_LAST) ? 12'd0 : v_r + 12'd1;
                end else begin
                    h_r <= h_r + 12'd1;
                end
            end else begin
                pix_r <= pix_r + 16'd1;
            end
            vga_hsync <= !((h_r >= HS_START) && (h_r <= HS_END));
            vga_vsync <= !((v_r >= VS_START) && (v_r <= VS_END));
            if ((h_r < H_ACT_L) && (v_r < V_ACT_L)) begin
                vga_red   <= h_r[7:4];
                vga_green <= v_r[7:4];
                vga_blue  <= h_r[3:0] ^ v_r[3:0];
            end else begin
                vga_red   <= 4'd0;
                vga_green <= 4'd0;
                vga_blue  <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_chip_top.sv
// Bench for chip_top: UART scoreboard, SPI event recorder, VGA timing model, table-driven echo vectors.
`timescale 1ns/1ps
module tb_chip_top;

    localparam int BAUD = 16;
    localparam int SPI  = 4;
    localparam int PIX  = 2;
    localparam int HA = 40, HF = 2, HS = 4, HB = 2;
    localparam int VA = 24, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk_p = 1'b0;
    logic       clk_n;
    logic       rst_top;
    logic       rxd;
    logic       txd;
    logic       spi_cs;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       sd_reset;
    logic [3:0] vga_red;
    logic [3:0] vga_green;
    logic [3:0] vga_blue;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       miso_loop;

    int checks = 0;
    int errors = 0;

    chip_top #(
        .BAUD_DIV(BAUD), .SPI_DIV(SPI), .PIX_DIV(PIX),
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk_p(clk_p), .clk_n(clk_n), .rst_top(rst_top), .rxd(rxd), .txd(txd),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .sd_reset(sd_reset), .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
    );

    always #2.5 clk_p = ~clk_p;
    assign clk_n    = ~clk_p;
    assign spi_miso = (miso_loop && !spi_cs) ? spi_mosi : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard and monitor state
    logic [7:0] exp_q[$];
    int         starts[$];
    int         rise_q[$];
    int         fall_q[$];
    int         cyc = 0;
    int         mon_count = 0;
    logic       mon_busy = 1'b0;
    int         mon_cnt;
    logic [7:0] mon_byte;
    logic [7:0] exp_b;
    logic [7:0] spi_bits;
    int         cs_fall, cs_rise, sd_fall;
    logic       p_sclk = 1'b0, p_cs = 1'b1, p_sd = 1'b1;
    logic       samp_rst;
    int         vk = 0, n, hh, vv, hs_run = 0, vs_run = 0;
    logic [11:0] hb, vb;
    logic [13:0] vexp;

    always @(posedge clk_p) begin
        samp_rst = rst_top;
        #1;
        cyc++;
        // VGA reference: outputs after the k-th released edge show pixel (k-1)/PIX
        if (samp_rst) begin
            vk = 0;
            vexp = {12'h000, 1'b1, 1'b1};
            hh = -1;
            vv = -1;
        end else begin
            vk++;
            n  = (vk - 1) / PIX;
            hh = n % HT;
            vv = (n / HT) % VT;
            hb = 12'(hh);
            vb = 12'(vv);
            vexp[1] = !(hh >= HA + HF && hh < HA + HF + HS);
            vexp[0] = !(vv >= VA + VF && vv < VA + VF + VS);
            vexp[13:2] = (hh < HA && vv < VA) ? {hb[7:4], vb[7:4], hb[3:0] ^ vb[3:0]} : 12'h000;
        end
        chk("vga_outputs", {18'h0, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync}, {18'h0, vexp});
        if (hh == 37 && vv == 19)
            chk("pixel_25_13", {20'h0, vga_red, vga_green, vga_blue}, {20'h0, 4'd2, 4'd1, 4'd6});
        if (samp_rst) begin
            hs_run = 0;
            vs_run = 0;
        end else begin
            if (!vga_hsync) hs_run++;
            else begin
                if (hs_run != 0) chk("hsync_width", hs_run, HS * PIX);
                hs_run = 0;
            end
            if (!vga_vsync) vs_run++;
            else begin
                if (vs_run != 0) chk("vsync_width", vs_run, VS * HT * PIX);
                vs_run = 0;
            end
        end

        // UART monitor: sample each bit at its centre, compare against the scoreboard
        if (samp_rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (txd === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % BAUD == BAUD / 2) begin
                if (mon_cnt / BAUD == 0) begin
                    chk("tx_start_bit", txd, 0);
                end else if (mon_cnt / BAUD <= 8) begin
                    mon_byte[mon_cnt / BAUD - 1] = txd;
                end else begin
                    chk("tx_stop_bit", txd, 1);
                    chk("tx_byte_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        chk("tx_byte", mon_byte, exp_b);
                    end
                    mon_count++;
                    mon_busy = 1'b0;
                end
            end
        end

        // SPI / sd_reset event recorder
        if (!samp_rst) begin
            if (!p_sclk && spi_sclk) begin
                rise_q.push_back(cyc);
                spi_bits = {spi_bits[6:0], spi_mosi};
            end
            if (p_sclk && !spi_sclk) fall_q.push_back(cyc);
            if (p_cs && !spi_cs) cs_fall = cyc;
            if (!p_cs && spi_cs) cs_rise = cyc;
            if (p_sd && !sd_reset) sd_fall = cyc;
        end
        p_sclk = spi_sclk;
        p_cs   = spi_cs;
        p_sd   = sd_reset;
    end

    task automatic wait_q(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk_p);
            k++;
        end
        if (exp_q.size() != 0) chk("scoreboard_timeout", exp_q.size(), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_p);
            rxd = frame[i];
            repeat (BAUD - 1) @(negedge clk_p);
        end
        if (!stop_bit) begin
            @(negedge clk_p);
            rxd = 1'b1;
        end
    endtask

    task automatic clear_records();
        exp_q.delete();
        starts.delete();
        rise_q.delete();
        fall_q.delete();
        spi_bits = 8'h00;
        cs_fall  = -1;
        cs_rise  = -1;
        sd_fall  = -1;
    endtask

    task automatic push_sequence(input logic [7:0] verdict);
        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h4B);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        exp_q.push_back(verdict);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       glitch;
        logic       echo;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h41, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b1};

        rst_top   = 1'b1;
        rxd       = 1'b1;
        miso_loop = 1'b1;
        clear_records();
        repeat (26) @(negedge clk_p);
        chk("reset_outputs",
            {11'h0, txd, spi_cs, spi_sclk, spi_mosi, sd_reset, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync},
            {11'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b1});

        // loopback run: banner then 'P'
        push_sequence(8'h50);
        rst_top = 1'b0;
        lat = 0;
        @(posedge clk_p); #1;
        while (txd !== 1'b0 && lat < 10) begin
            lat++;
            @(posedge clk_p); #1;
        end
        chk("banner_start_latency", lat <= 1, 1);
        chk("sd_reset_in_banner", sd_reset, 1);
        wait_q(3000);
        chk("seq1_byte_count", starts.size(), 5);
        for (int i = 0; i < 3; i++)
            if (i + 1 < starts.size()) chk($sformatf("banner_gap_%0d", i), starts[i+1] - starts[i], 10 * BAUD);
        chk("loopback_mosi_bits", spi_bits, 8'hA5);
        chk("sd_reset_after_spi", sd_reset, 0);

        // echo vectors
        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].echo) begin
                wait_q(2000);
                base = mon_count;
                if (vecs[i].glitch) begin
                    @(negedge clk_p);
                    rxd = 1'b0;
                    @(negedge clk_p);
                    rxd = 1'b1;
                end else begin
                    send_byte(vecs[i].data, vecs[i].stop_ok);
                end
                repeat (400) @(negedge clk_p);
                chk($sformatf("no_echo_%0d", i), mon_count, base);
            end else begin
                exp_q.push_back(vecs[i].data);
                send_byte(vecs[i].data, vecs[i].stop_ok);
            end
        end
        wait_q(2000);

        // stuck-low MISO run: verdict 'F', SPI waveform timing
        @(negedge clk_p);
        rst_top   = 1'b1;
        miso_loop = 1'b0;
        repeat (4) @(negedge clk_p);
        clear_records();
        push_sequence(8'h46);
        rst_top = 1'b0;
        wait_q(3000);
        chk("spi_mosi_bits", spi_bits, 8'hA5);
        chk("spi_rise_count", rise_q.size(), 8);
        chk("spi_fall_count", fall_q.size(), 8);
        if (rise_q.size() == 8 && fall_q.size() == 8) begin
            chk("spi_first_rise", rise_q[0] - cs_fall, SPI);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("spi_high_%0d", i), fall_q[i] - rise_q[i], SPI);
                if (i < 7) chk($sformatf("spi_period_%0d", i), rise_q[i+1] - rise_q[i], 2 * SPI);
            end
            chk("spi_cs_release", cs_rise - fall_q[7], SPI);
        end
        chk("sd_reset_fall_at_spi", sd_fall, cs_fall);

        // reset during the second banner byte
        @(negedge clk_p);
        rst_top   = 1'b1;
        miso_loop = 1'b1;
        repeat (3) @(negedge clk_p);
        clear_records();
        exp_q.push_back(8'h4F);
        rst_top = 1'b0;
        wait_q(1000);
        repeat (12) @(negedge clk_p);
        chk("abort_txd_before", txd, 0);
        rst_top = 1'b1;
        @(posedge clk_p); #1;
        chk("abort_txd_after", txd, 1);
        chk("abort_sd_reset", sd_reset, 1);
        repeat (3) @(negedge clk_p);
        clear_records();
        push_sequence(8'h50);
        rst_top = 1'b0;
        wait_q(3000);
        chk("restart_byte_count", starts.size(), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
